// File: rtl/neopixel_pkg.sv
// Shared WS2812 constants and receiver state type.
package neopixel_pkg;

    localparam int unsigned PIXEL_W   = 24;
    localparam int unsigned BIT_CNT_W = 5;
    localparam int unsigned CNT_W     = 16;

    // Pulse timing in cycles at 27 MHz, shared with the transmit driver
    localparam int unsigned T_THRESH_DEF   = 16;
    localparam int unsigned T_MAX_HIGH_DEF = 54;
    localparam int unsigned T_RESET_DEF    = 1350;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        IDLE = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/neopixel_rx_sync.sv
// Two-flop synchronizer for the raw data line plus a registered edge detector.
module neopixel_rx_sync (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_din,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic meta_q;
    logic sync_q;

    // Synchronize, then register level and edge pulses together so they stay aligned
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            o_level <= 1'b0;
            o_rise  <= 1'b0;
            o_fall  <= 1'b0;
        end else begin
            meta_q  <= i_din;
            sync_q  <= meta_q;
            o_level <= sync_q;
            o_rise  <= sync_q & ~o_level;
            o_fall  <= ~sync_q & o_level;
        end
    end

endmodule

// File: rtl/neopixel_receiver.sv
// WS2812 line decoder: classifies bits by high time, assembles GRB pixels and
// writes them sequentially into a pixel buffer, one frame per latch gap.
module neopixel_receiver
    import neopixel_pkg::*;
#(
    parameter int unsigned T_THRESH   = T_THRESH_DEF,
    parameter int unsigned T_MAX_HIGH = T_MAX_HIGH_DEF,
    parameter int unsigned T_RESET    = T_RESET_DEF,
    parameter int unsigned ADDR_W     = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_din,
    output logic               o_wr_en,
    output logic [ADDR_W-1:0]  o_wr_addr,
    output logic [PIXEL_W-1:0] o_wr_data,
    output logic               o_frame_done,
    output logic [ADDR_W:0]    o_pixel_count,
    output logic               o_err
);

    localparam int unsigned IDX_W = ADDR_W + 1;

    // cnt_q clears on the registered edge pulse, so it lags the elapsed time by one
    localparam logic [CNT_W-1:0]     THRESH_M1   = CNT_W'(T_THRESH - 1);
    localparam logic [CNT_W-1:0]     MAX_HIGH_M1 = CNT_W'(T_MAX_HIGH - 1);
    localparam logic [CNT_W-1:0]     RESET_M1    = CNT_W'(T_RESET - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT    = BIT_CNT_W'(PIXEL_W - 1);
    localparam logic [IDX_W-1:0]     PIX_MAX     = IDX_W'(1 << ADDR_W);

    logic line_level;
    logic line_rise;
    logic line_fall;

    rx_state_e state_q;
    rx_state_e state_d;

    logic [CNT_W-1:0]     cnt_q;
    logic [PIXEL_W-2:0]   shift_q;
    logic [PIXEL_W-2:0]   shift_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q;
    logic [BIT_CNT_W-1:0] bit_cnt_d;
    logic [IDX_W-1:0]     pix_idx_q;
    logic [IDX_W-1:0]     pix_idx_d;

    logic               wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_d;
    logic [PIXEL_W-1:0] wr_data_d;
    logic               frame_done_d;
    logic [ADDR_W:0]    pixel_count_d;
    logic               err_d;

    logic bit_c;
    logic stuck_c;
    logic gap_c;

    neopixel_rx_sync u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_din   (i_din),
        .o_level (line_level),
        .o_rise  (line_rise),
        .o_fall  (line_fall)
    );

    assign bit_c   = (cnt_q >= THRESH_M1);
    assign stuck_c = (cnt_q >= MAX_HIGH_M1);
    assign gap_c   = (cnt_q >= RESET_M1);

    // Pulse-width counter: restarts on every edge, saturates at all-ones
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else if (line_rise || line_fall) begin
            cnt_q <= '0;
        end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; in LOW a new bit wins over a coincident gap timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            SYNC: if (!line_level && gap_c) state_d = IDLE;
            IDLE: if (line_rise) state_d = HIGH;
            HIGH: begin
                if (stuck_c) begin
                    state_d = SYNC;
                end else if (line_fall) begin
                    state_d = LOW;
                end
            end
            LOW: begin
                if (line_rise) begin
                    state_d = HIGH;
                end else if (gap_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    // Datapath and next output values: bit shift, pixel write/drop, frame end, errors
    always_comb begin
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        pix_idx_d     = pix_idx_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = o_wr_addr;
        wr_data_d     = o_wr_data;
        frame_done_d  = 1'b0;
        pixel_count_d = o_pixel_count;
        err_d         = 1'b0;
        case (state_q)
            HIGH: begin
                if (stuck_c) begin
                    err_d     = 1'b1;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                    pix_idx_d = '0;
                end else if (line_fall) begin
                    shift_d = {shift_q[PIXEL_W-3:0], bit_c};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        if (pix_idx_q == PIX_MAX) begin
                            err_d = 1'b1;
                        end else begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = pix_idx_q[ADDR_W-1:0];
                            wr_data_d = {shift_q, bit_c};
                            pix_idx_d = pix_idx_q + IDX_W'(1);
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            LOW: begin
                if (!line_rise && gap_c) begin
                    frame_done_d  = 1'b1;
                    pixel_count_d = pix_idx_q;
                    err_d         = (bit_cnt_q != '0);
                    wr_addr_d     = '0;
                    pix_idx_d     = '0;
                    bit_cnt_d     = '0;
                    shift_d       = '0;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            pix_idx_q     <= '0;
            o_wr_en       <= 1'b0;
            o_wr_addr     <= '0;
            o_wr_data     <= '0;
            o_frame_done  <= 1'b0;
            o_pixel_count <= '0;
            o_err         <= 1'b0;
        end else begin
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            pix_idx_q     <= pix_idx_d;
            o_wr_en       <= wr_en_d;
            o_wr_addr     <= wr_addr_d;
            o_wr_data     <= wr_data_d;
            o_frame_done  <= frame_done_d;
            o_pixel_count <= pixel_count_d;
            o_err         <= err_d;
        end
    end

endmodule

// File: tb/tb_neopixel_receiver.sv
// Bench for neopixel_receiver: drives WS2812 waveforms and compares the
// buffer writes against a pixel-level model of the line protocol.
module tb_neopixel_receiver;
    import neopixel_pkg::*;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned NPIX   = 1 << ADDR_W;
    localparam int unsigned LOG_N  = 1024;

    logic              clk = 1'b0;
    logic              rst;
    logic              din;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [23:0]       wr_data;
    logic              frame_done;
    logic [ADDR_W:0]   pixel_count;
    logic              err;

    neopixel_receiver #(
        .T_THRESH   (T_THRESH_DEF),
        .T_MAX_HIGH (T_MAX_HIGH_DEF),
        .T_RESET    (T_RESET_DEF),
        .ADDR_W     (ADDR_W)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_din         (din),
        .o_wr_en       (wr_en),
        .o_wr_addr     (wr_addr),
        .o_wr_data     (wr_data),
        .o_frame_done  (frame_done),
        .o_pixel_count (pixel_count),
        .o_err         (err)
    );

    always #5 clk = ~clk;

    // Cycle stamp and event log, sampled on the falling clock edge
    int unsigned       cyc = 0;
    int unsigned       wr_n = 0;
    int unsigned       fd_n = 0;
    int unsigned       err_n = 0;
    logic [ADDR_W-1:0] log_addr [LOG_N];
    logic [23:0]       log_data [LOG_N];
    int unsigned       log_cyc  [LOG_N];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en === 1'b1 && wr_n < LOG_N) begin
            log_addr[wr_n] <= wr_addr;
            log_data[wr_n] <= wr_data;
            log_cyc[wr_n]  <= cyc;
            wr_n           <= wr_n + 1;
        end
        if (frame_done === 1'b1) fd_n <= fd_n + 1;
        if (err === 1'b1) err_n <= err_n + 1;
    end

    // Reference model: pixels decoded from the high times actually driven
    int          errors = 0;
    int          checks = 0;
    logic [23:0] m_acc;
    int unsigned m_nb;
    logic [23:0] m_px [$];
    int unsigned base_wr, base_fd, base_err;
    int unsigned last_fall;

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_acc = '0;
        m_nb  = 0;
        m_px.delete();
        base_wr  = wr_n;
        base_fd  = fd_n;
        base_err = err_n;
    endtask

    task automatic send_bit(input int unsigned h, input int unsigned l);
        din = 1'b1;
        tick(h);
        din = 1'b0;
        last_fall = cyc;
        tick(l);
        m_acc = {m_acc[22:0], (h >= T_THRESH_DEF) ? 1'b1 : 1'b0};
        m_nb++;
        if (m_nb == 24) begin
            m_px.push_back(m_acc);
            m_nb = 0;
        end
    endtask

    task automatic send_pixel(input logic [23:0] data, input int unsigned t0h,
                              input int unsigned t1h, input int unsigned per);
        int unsigned h;
        for (int b = 23; b >= 0; b--) begin
            h = data[b] ? t1h : t0h;
            send_bit(h, per - h);
        end
    endtask

    task automatic send_rand_pixel();
        for (int b = 0; b < 24; b++) begin
            send_bit($urandom_range(45, 1), $urandom_range(40, 3));
        end
    endtask

    task automatic gap(input int unsigned n);
        din = 1'b0;
        tick(n);
    endtask

    // Frame-level expectations after a latch gap: writes, drops, partial bits
    task automatic check_frame(input string tag);
        int unsigned n, nw, ne;
        n  = m_px.size();
        nw = (n > NPIX) ? NPIX : n;
        ne = ((n > NPIX) ? n - NPIX : 0) + ((m_nb != 0) ? 1 : 0);
        chk($sformatf("%s_wr_count", tag), wr_n - base_wr, nw);
        for (int i = 0; i < int'(nw); i++) begin
            if (base_wr + i < LOG_N) begin
                chk($sformatf("%s_addr%0d", tag, i), 32'(log_addr[base_wr+i]), i);
                chk($sformatf("%s_data%0d", tag, i), 32'(log_data[base_wr+i]), 32'(m_px[i]));
            end
        end
        chk($sformatf("%s_frame_done", tag), fd_n - base_fd, 1);
        chk($sformatf("%s_err", tag), err_n - base_err, ne);
        chk($sformatf("%s_pixel_count", tag), 32'(pixel_count), nw);
        chk($sformatf("%s_addr_idle", tag), 32'(wr_addr), 0);
        model_clear();
    endtask

    initial begin
        logic [23:0] d;

        // Reset values
        rst = 1'b1;
        din = 1'b0;
        tick(3);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_pixel_count", 32'(pixel_count), 0);
        chk("rst_err", 32'(err), 0);
        rst = 1'b0;
        gap(1400);
        model_clear();

        // Single pixel, write latency 3 detect cycles + 1
        send_pixel(24'hA53CF0, 11, 22, 34);
        gap(1400);
        chk("t1_wr_latency", log_cyc[base_wr] - last_fall, 4);
        chk("t1_data_const", 32'(log_data[base_wr]), 32'hA53CF0);
        check_frame("t1");

        // Three back-to-back pixels
        send_pixel(24'hFF0000, 11, 22, 34);
        send_pixel(24'h00FF00, 11, 22, 34);
        send_pixel(24'h0000FF, 11, 22, 34);
        gap(1400);
        chk("t2_pixel_count", 32'(pixel_count), 3);
        check_frame("t2");

        // Threshold boundary: 16 high is a 1, 15 high is a 0
        for (int b = 0; b < 24; b++) begin
            send_bit((b == 0) ? 16 : 15, (b == 0) ? 18 : 19);
        end
        gap(1400);
        chk("t3_data_const", 32'(log_data[base_wr]), 32'h800000);
        check_frame("t3");

        // Stuck-high mid-pixel; traffic is ignored until a full latch gap
        for (int b = 0; b < 5; b++) send_bit(22, 12);
        din = 1'b1;
        tick(60);
        gap(100);
        send_pixel(24'h123456, 11, 22, 34);
        gap(1400);
        chk("t4_stuck_err", err_n - base_err, 1);
        chk("t4_stuck_wr", wr_n - base_wr, 0);
        chk("t4_stuck_fd", fd_n - base_fd, 0);
        model_clear();
        send_pixel(24'h654321, 11, 22, 34);
        gap(1400);
        check_frame("t4");

        // Ten bits then a gap: partial pixel error, frame still ends
        for (int b = 0; b < 10; b++) send_bit((b % 2 == 0) ? 22 : 11, 12);
        gap(1400);
        check_frame("t5");

        // Random pixels and timing, with a sub-latch pause inside the frame
        send_rand_pixel();
        send_rand_pixel();
        gap(1200);
        send_rand_pixel();
        send_rand_pixel();
        send_rand_pixel();
        gap(1400);
        check_frame("t6");

        // 257 pixels: last one is dropped with an error, count saturates
        for (int i = 0; i < int'(NPIX) + 1; i++) begin
            d = 24'(i & 1);
            for (int b = 23; b >= 0; b--) send_bit(d[b] ? 16 : 2, 3);
        end
        gap(1400);
        check_frame("t7");

        // Reset mid-frame: outputs clear and the receiver resynchronizes
        for (int b = 0; b < 12; b++) send_bit(22, 12);
        rst = 1'b1;
        tick(1);
        chk("t8_wr_en", 32'(wr_en), 0);
        chk("t8_wr_addr", 32'(wr_addr), 0);
        chk("t8_wr_data", 32'(wr_data), 0);
        chk("t8_frame_done", 32'(frame_done), 0);
        chk("t8_pixel_count", 32'(pixel_count), 0);
        chk("t8_err", 32'(err), 0);
        rst = 1'b0;
        model_clear();
        gap(100);
        send_pixel(24'hABCDEF, 11, 22, 34);
        gap(1400);
        chk("t8_sync_wr", wr_n - base_wr, 0);
        chk("t8_sync_fd", fd_n - base_fd, 0);
        chk("t8_sync_err", err_n - base_err, 0);
        model_clear();
        send_pixel(24'h13579B, 11, 22, 34);
        gap(1400);
        check_frame("t8");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
